if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
Instruction fetch / IM_ID stage that sits directly downstream of the program counter block.
- Consumes the synchronous instruction-memory read data (addressed by pc one cycle earlier) and drives the registered instruction into ID.
- Squashes wrong-path words after a taken branch or jump.
- Diverts memory words fetched for LWI/movc accesses to a data output and inserts a bubble in their slot.
- Honours pipeline stalls.

Parameters:
NOP_INSTR, 16'h0000, bubble instruction loaded into instr_IM_ID on squash or movc slot.
SQUASH_CYC, 2, number of unstalled fetch slots replaced by NOP after flow_change_ID_EX (legal 1..3).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall_IM_ID  in  1  hold IM_ID register (same stall that holds the PC)
flow_change_ID_EX  in  1  taken branch/jump resolved in EX
LWI_instr_EX_DM  in  1  pc bus currently carries a movc data address
im_rdata  in  16  instruction memory read data (1-cycle sync read)
instr_IM_ID  out  16  instruction presented to decode
instr_vld_IM_ID  out  1  instr_IM_ID is a real, non-squashed instruction
movc_data  out  16  word returned from a movc/LWI fetch
movc_vld  out  1  one-cycle strobe: movc_data updated
squash_active  out  1  high while the state machine is in SQUASH

Behaviour:
- Reset (async, rst_n low): instr_IM_ID=NOP_INSTR, instr_vld_IM_ID=0, movc_data=0, movc_vld=0, squash_cnt=0, movc_pend=0, state=RUN. squash_active=0.
- All outputs are registered; update on posedge clk.
- States are RUN, SQUASH, MOVC.
- movc_pend: set on any edge where LWI_instr_EX_DM=1, regardless of stall; cleared otherwise. im_rdata in the cycle after LWI_instr_EX_DM is a data word.
- Edge with movc_pend=1 (state MOVC for that cycle):
  - movc_data<=im_rdata, movc_vld<=1.
  - If !stall_IM_ID: instr_IM_ID<=NOP_INSTR, instr_vld_IM_ID<=0. If stalled, the IM_ID register holds.
  - movc capture ignores stall.
- movc_vld is high exactly one cycle per capture. Back-to-back LWI cycles give consecutive captures with movc_vld held high.
- Edge with flow_change_ID_EX=1 and !stall_IM_ID:
  - instr_IM_ID<=NOP_INSTR, vld<=0.
  - squash_cnt<=SQUASH_CYC-1; state<=SQUASH if SQUASH_CYC>1, else RUN.
- flow_change_ID_EX while stalled is ignored (the PC also ignores it).
- SQUASH, unstalled edge: load NOP, vld=0, decrement squash_cnt; at 0 go to RUN. Stalled edge: hold everything, counter frozen.
- flow_change_ID_EX during SQUASH reloads the counter as above (restart, not accumulate).
- RUN, unstalled, no event: instr_IM_ID<=im_rdata, vld<=1.
- RUN, stalled: hold instr_IM_ID and vld.
- Priority on the same edge: reset > flow_change_ID_EX > movc_pend > SQUASH count > normal load.
  - A movc capture still updates movc_data/movc_vld when flow_change wins the IM_ID slot.
- squash_active = (state==SQUASH). It is registered and combinational-free.
- Interface contract: the hazard unit asserts stall_IM_ID during any LWI_instr_EX_DM cycle. This block does not check the contract.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt[15:0] and movc_cnt[15:0].
  - bubble_cnt increments on every unstalled edge that loads NOP_INSTR (squash or movc).
  - movc_cnt increments on every movc capture.
  - Both counters wrap 16'hFFFF->0 and reset to 0.
- Undefined: no counters and no ports; all other behaviour is identical.

Test Plan:
1. Reset then im_rdata=16'h1234, no stall -> instr_IM_ID=16'h0000/vld=0 during reset; one edge after release: 16'h1234, vld=1.
2. Stream 16'hA001,A002,A003; stall_IM_ID high for 2 cycles on A002 -> instr_IM_ID holds 16'hA002 for 3 cycles, then 16'hA003.
3. flow_change_ID_EX pulse with SQUASH_CYC=2 -> two edges load 16'h0000 with vld=0 and squash_active=1 for one cycle; third edge loads im_rdata with vld=1.
4. flow_change_ID_EX during SQUASH, with one stall cycle inside -> counter reloads to 1 and is frozen over the stall; 2 NOP slots after the restart.
5. LWI_instr_EX_DM=1 with stall, next cycle im_rdata=16'hBEEF -> movc_data=16'hBEEF, movc_vld high exactly 1 cycle, instr_IM_ID unchanged.
6. rst_n asserted mid-SQUASH -> outputs return immediately (async) to reset values; squash_active=0; the first post-reset edge loads im_rdata.

Source files
------------

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - IM_ID fetch stage: squash, movc diversion, stall hold (opt. FETCH_PERF_CNT_EN counters)
module if_id_fetch_stage #(
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter int          SQUASH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_IM_ID,
    input  logic        flow_change_ID_EX,
    input  logic        LWI_instr_EX_DM,
    input  logic [15:0] im_rdata,
    output logic [15:0] instr_IM_ID,
    output logic        instr_vld_IM_ID,
    output logic [15:0] movc_data,
    output logic        movc_vld,
`ifdef FETCH_PERF_CNT_EN
    output logic        squash_active,
    output logic [15:0] bubble_cnt,
    output logic [15:0] movc_cnt
`else
    output logic        squash_active
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_MOVC   = 2'd2
    } state_t;

    localparam logic [1:0] SQ_RELOAD = 2'(SQUASH_CYC - 1);
    localparam state_t     FC_STATE  = (SQUASH_CYC > 1) ? ST_SQUASH : ST_RUN;

    state_t      state_q, state_d;
    logic [1:0]  squash_cnt_q, squash_cnt_d;
    logic        movc_pend_q, movc_pend_d;
    logic [15:0] instr_q, instr_d;
    logic        vld_q, vld_d;
    logic [15:0] movc_data_q, movc_data_d;
    logic        movc_vld_q, movc_vld_d;
    logic        load_nop;
    logic [1:0]  squash_dec;

    always_comb begin
        state_d      = state_q;
        squash_cnt_d = squash_cnt_q;
        movc_pend_d  = LWI_instr_EX_DM;
        instr_d      = instr_q;
        vld_d        = vld_q;
        movc_data_d  = movc_data_q;
        movc_vld_d   = 1'b0;
        load_nop     = 1'b0;
        squash_dec   = squash_cnt_q - 2'd1;

        // The data word is captured even when flow_change takes the IM_ID slot.
        if (movc_pend_q) begin
            movc_data_d = im_rdata;
            movc_vld_d  = 1'b1;
        end

        if (!stall_IM_ID) begin
            if (flow_change_ID_EX) begin
                load_nop     = 1'b1;
                squash_cnt_d = SQ_RELOAD;
                state_d      = FC_STATE;
            end else if (movc_pend_q) begin
                load_nop = 1'b1;
                state_d  = (state_q == ST_SQUASH) ? ST_SQUASH : ST_RUN;
            end else if (state_q == ST_SQUASH) begin
                load_nop     = 1'b1;
                squash_cnt_d = squash_dec;
                if (squash_dec == 2'd0) begin
                    state_d = ST_RUN;
                end
            end else begin
                instr_d = im_rdata;
                vld_d   = 1'b1;
                state_d = ST_RUN;
            end
        end else if (state_q == ST_MOVC && movc_pend_q) begin
            state_d = ST_RUN;
        end

        if (LWI_instr_EX_DM && state_d == ST_RUN) begin
            state_d = ST_MOVC;
        end

        if (load_nop) begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            squash_cnt_q <= 2'd0;
            movc_pend_q  <= 1'b0;
            instr_q      <= NOP_INSTR;
            vld_q        <= 1'b0;
            movc_data_q  <= 16'h0000;
            movc_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            squash_cnt_q <= squash_cnt_d;
            movc_pend_q  <= movc_pend_d;
            instr_q      <= instr_d;
            vld_q        <= vld_d;
            movc_data_q  <= movc_data_d;
            movc_vld_q   <= movc_vld_d;
        end
    end

    assign instr_IM_ID     = instr_q;
    assign instr_vld_IM_ID = vld_q;
    assign movc_data       = movc_data_q;
    assign movc_vld        = movc_vld_q;
    assign squash_active   = (state_q == ST_SQUASH);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] movc_cnt_q, movc_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q + {15'd0, load_nop};
        movc_cnt_d   = movc_cnt_q + {15'd0, movc_pend_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'h0000;
            movc_cnt_q   <= 16'h0000;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            movc_cnt_q   <= movc_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign movc_cnt   = movc_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - directed vector bench for if_id_fetch_stage
module tb_if_id_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_IM_ID;
    logic        flow_change_ID_EX;
    logic        LWI_instr_EX_DM;
    logic [15:0] im_rdata;
    logic [15:0] instr_IM_ID;
    logic        instr_vld_IM_ID;
    logic [15:0] movc_data;
    logic        movc_vld;
    logic        squash_active;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] bubble_cnt;
    logic [15:0] movc_cnt;
`endif

    if_id_fetch_stage #(
        .NOP_INSTR (16'h0000),
        .SQUASH_CYC(2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_IM_ID      (stall_IM_ID),
        .flow_change_ID_EX(flow_change_ID_EX),
        .LWI_instr_EX_DM  (LWI_instr_EX_DM),
        .im_rdata         (im_rdata),
        .instr_IM_ID      (instr_IM_ID),
        .instr_vld_IM_ID  (instr_vld_IM_ID),
        .movc_data        (movc_data),
        .movc_vld         (movc_vld),
`ifdef FETCH_PERF_CNT_EN
        .squash_active    (squash_active),
        .bubble_cnt       (bubble_cnt),
        .movc_cnt         (movc_cnt)
`else
        .squash_active    (squash_active)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flow;
        logic        lwi;
        logic [15:0] rd;
        logic [15:0] e_instr;
        logic        e_vld;
        logic [15:0] e_md;
        logic        e_mv;
        logic        e_sq;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic s, input logic f, input logic l, input logic [15:0] rd,
                       input logic [15:0] ei, input logic ev, input logic [15:0] emd,
                       input logic emv, input logic esq);
        vec_t v;
        v.stall = s; v.flow = f; v.lwi = l; v.rd = rd;
        v.e_instr = ei; v.e_vld = ev; v.e_md = emd; v.e_mv = emv; v.e_sq = esq;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] ei, input logic ev,
                         input logic [15:0] emd, input logic emv, input logic esq);
        checks++;
        if (instr_IM_ID !== ei || instr_vld_IM_ID !== ev || movc_data !== emd ||
            movc_vld !== emv || squash_active !== esq) begin
            errors++;
            $display("FAIL %s: got instr=%h vld=%b md=%h mv=%b sq=%b, want instr=%h vld=%b md=%h mv=%b sq=%b",
                     name, instr_IM_ID, instr_vld_IM_ID, movc_data, movc_vld, squash_active,
                     ei, ev, emd, emv, esq);
        end
    endtask

    initial begin
        // stall flow lwi rdata | instr vld movc_data movc_vld squash
        add(0,0,0,16'h1234, 16'h1234,1,16'h0000,0,0);
        add(0,0,0,16'hA001, 16'hA001,1,16'h0000,0,0);
        add(0,0,0,16'hA002, 16'hA002,1,16'h0000,0,0);
        add(1,0,0,16'hA003, 16'hA002,1,16'h0000,0,0);
        add(1,0,0,16'hA003, 16'hA002,1,16'h0000,0,0);
        add(0,0,0,16'hA003, 16'hA003,1,16'h0000,0,0);
        add(0,1,0,16'hA004, 16'h0000,0,16'h0000,0,1);
        add(0,0,0,16'hA005, 16'h0000,0,16'h0000,0,0);
        add(0,0,0,16'hA006, 16'hA006,1,16'h0000,0,0);
        add(0,1,0,16'hB001, 16'h0000,0,16'h0000,0,1);
        add(0,1,0,16'hB002, 16'h0000,0,16'h0000,0,1);
        add(1,0,0,16'hB003, 16'h0000,0,16'h0000,0,1);
        add(0,0,0,16'hB004, 16'h0000,0,16'h0000,0,0);
        add(0,0,0,16'hB005, 16'hB005,1,16'h0000,0,0);
        add(1,0,1,16'hC000, 16'hB005,1,16'h0000,0,0);
        add(1,0,0,16'hBEEF, 16'hB005,1,16'hBEEF,1,0);
        add(0,0,0,16'hC001, 16'hC001,1,16'hBEEF,0,0);
        add(1,0,1,16'hC002, 16'hC001,1,16'hBEEF,0,0);
        add(0,0,0,16'h5A5A, 16'h0000,0,16'h5A5A,1,0);
        add(0,0,0,16'hC003, 16'hC003,1,16'h5A5A,0,0);
        add(1,0,1,16'h9999, 16'hC003,1,16'h5A5A,0,0);
        add(1,0,1,16'h1111, 16'hC003,1,16'h1111,1,0);
        add(1,0,0,16'h2222, 16'hC003,1,16'h2222,1,0);
        add(0,0,0,16'hC004, 16'hC004,1,16'h2222,0,0);
        add(1,0,1,16'h0000, 16'hC004,1,16'h2222,0,0);
        add(0,1,0,16'h3333, 16'h0000,0,16'h3333,1,1);
        add(0,0,0,16'hC005, 16'h0000,0,16'h3333,0,0);
        add(0,0,0,16'hC006, 16'hC006,1,16'h3333,0,0);
        add(1,1,0,16'hC007, 16'hC006,1,16'h3333,0,0);
        add(0,0,0,16'hC008, 16'hC008,1,16'h3333,0,0);

        rst_n = 1'b0;
        stall_IM_ID = 1'b0;
        flow_change_ID_EX = 1'b0;
        LWI_instr_EX_DM = 1'b0;
        im_rdata = 16'h1234;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_hold", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            stall_IM_ID       = tv[i].stall;
            flow_change_ID_EX = tv[i].flow;
            LWI_instr_EX_DM   = tv[i].lwi;
            im_rdata          = tv[i].rd;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), tv[i].e_instr, tv[i].e_vld, tv[i].e_md, tv[i].e_mv, tv[i].e_sq);
        end

        // Asynchronous reset in the middle of a squash window.
        stall_IM_ID = 1'b0;
        flow_change_ID_EX = 1'b1;
        im_rdata = 16'hD001;
        @(posedge clk); #1;
        check("pre_async_squash", 16'h0000, 1'b0, 16'h3333, 1'b0, 1'b1);
        flow_change_ID_EX = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("async_reset", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        im_rdata = 16'h7777;
        @(posedge clk); #1;
        check("post_reset_load", 16'h7777, 1'b1, 16'h0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
